// File: rtl/aes_pkg.sv
// Shared AES GF(2^8) helpers, widths and FSM encoding for the InvMixColumns block.
package aes_pkg;
  localparam int          COL_W   = 32;
  localparam int          BYTE_W  = 8;
  localparam logic [7:0]  GF_POLY = 8'h1B;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_CALC = 2'd1;
  localparam state_t ST_DONE = 2'd2;

  function automatic logic [BYTE_W-1:0] xtime(input logic [BYTE_W-1:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? GF_POLY : 8'h00);
  endfunction

  // Only the InvMixColumns coefficients are needed; anything else passes b through.
  function automatic logic [BYTE_W-1:0] gf_mul(input logic [BYTE_W-1:0] b, input logic [3:0] k);
    logic [BYTE_W-1:0] x2, x4, x8;
    x2 = xtime(b);
    x4 = xtime(x2);
    x8 = xtime(x4);
    case (k)
      4'h9:    return x8 ^ b;
      4'hB:    return x8 ^ x2 ^ b;
      4'hD:    return x8 ^ x4 ^ b;
      4'hE:    return x8 ^ x4 ^ x2;
      default: return b;
    endcase
  endfunction
endpackage

// File: rtl/aes_inv_mix_single_column.sv
// Combinational InvMixColumns of one 32-bit column; row 0 is the MSB byte.
module aes_inv_mix_single_column
  import aes_pkg::*;
(
  input  logic [COL_W-1:0] col_in,
  output logic [COL_W-1:0] col_out
);
  logic [BYTE_W-1:0] a0, a1, a2, a3, r0, r1, r2, r3;

  assign {a0, a1, a2, a3} = col_in;

  assign r0 = gf_mul(a0, 4'hE) ^ gf_mul(a1, 4'hB) ^ gf_mul(a2, 4'hD) ^ gf_mul(a3, 4'h9);
  assign r1 = gf_mul(a0, 4'h9) ^ gf_mul(a1, 4'hE) ^ gf_mul(a2, 4'hB) ^ gf_mul(a3, 4'hD);
  assign r2 = gf_mul(a0, 4'hD) ^ gf_mul(a1, 4'h9) ^ gf_mul(a2, 4'hE) ^ gf_mul(a3, 4'hB);
  assign r3 = gf_mul(a0, 4'hB) ^ gf_mul(a1, 4'hD) ^ gf_mul(a2, 4'h9) ^ gf_mul(a3, 4'hE);

  assign col_out = {r0, r1, r2, r3};
endmodule

// File: rtl/aes_inv_mix_column_iter.sv
// Iterative AES InvMixColumns: COLS_PER_CYCLE columns per cycle, valid/ready on both sides.
module aes_inv_mix_column_iter
  import aes_pkg::*;
#(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [127:0] i_aes_inv_mix_column_data_in,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [127:0] o_aes_inv_mix_column_data_out,
  output logic         o_busy
);
  localparam int         NUM_GRP  = 4 / COLS_PER_CYCLE;
  localparam logic [1:0] LAST_GRP = 2'(NUM_GRP - 1);

  if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cfg
    $error("aes_inv_mix_column_iter: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  state_t                    state_q;
  logic [1:0]                cnt_q;
  // Index 3 holds column 0 so the packed layout matches the 128-bit port.
  logic [3:0][COL_W-1:0]     din_q, dout_q;
  logic [COLS_PER_CYCLE-1:0][COL_W-1:0] lane_in, lane_out;
  logic [COLS_PER_CYCLE-1:0][1:0]       lane_col;

  for (genvar j = 0; j < COLS_PER_CYCLE; j++) begin : g_lane
    assign lane_col[j] = 2'(int'(cnt_q) * COLS_PER_CYCLE + j);
    assign lane_in[j]  = din_q[2'd3 - lane_col[j]];
    aes_inv_mix_single_column u_col (
      .col_in  (lane_in[j]),
      .col_out (lane_out[j])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 2'd0;
      dout_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (i_valid) begin
            din_q   <= i_aes_inv_mix_column_data_in;
            cnt_q   <= 2'd0;
            state_q <= ST_CALC;
          end
        end
        ST_CALC: begin
          for (int j = 0; j < COLS_PER_CYCLE; j++)
            dout_q[2'd3 - lane_col[j]] <= lane_out[j];
          if (cnt_q == LAST_GRP) state_q <= ST_DONE;
          else                   cnt_q   <= cnt_q + 2'd1;
        end
        ST_DONE: begin
          if (i_ready) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Handshake outputs are masked by rst so reset wins over any same-cycle transfer.
  assign o_ready = (state_q == ST_IDLE) && !rst;
  assign o_valid = (state_q == ST_DONE) && !rst;
  assign o_busy  = ((state_q == ST_CALC) || (state_q == ST_DONE)) && !rst;
  assign o_aes_inv_mix_column_data_out = dout_q;
endmodule

// File: tb/tb_aes_inv_mix_column_iter.sv
// Directed and round-trip checks of aes_inv_mix_column_iter for COLS_PER_CYCLE = 1, 2, 4.
module tb_aes_inv_mix_column_iter;
  localparam int NRT = 1000;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [2:0]   iv = '0, ir = '0;
  logic [2:0]   ordy, ov, obusy;
  logic [127:0] din  [3];
  logic [127:0] dout [3];
  logic [127:0] orig [NRT];
  int n_chk = 0, n_err = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    aes_inv_mix_column_iter #(.COLS_PER_CYCLE(1 << g)) u_dut (
      .clk                           (clk),
      .rst                           (rst),
      .i_valid                       (iv[g]),
      .o_ready                       (ordy[g]),
      .i_aes_inv_mix_column_data_in  (din[g]),
      .o_valid                       (ov[g]),
      .i_ready                       (ir[g]),
      .o_aes_inv_mix_column_data_out (dout[g]),
      .o_busy                        (obusy[g])
    );
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] xt(input logic [7:0] b);
    return (b << 1) ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Forward MixColumns, used to build inputs whose InvMixColumns is known.
  function automatic logic [127:0] fwd_mix(input logic [127:0] w);
    logic [127:0] r;
    logic [7:0] a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      {a0, a1, a2, a3} = w[127-32*c -: 32];
      r[127-32*c -: 32] = {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
                           a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
                           a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
                           xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wait_ready(input int l);
    int n = 0;
    while (!ordy[l] && n < 50) begin tick(); n++; end
    if (!ordy[l]) chk("ready_timeout", 0, 1);
  endtask

  task automatic wait_valid(input int l, output int n);
    n = 0;
    while (!ov[l] && n < 50) begin tick(); n++; end
    if (!ov[l]) chk("valid_timeout", 0, 1);
  endtask

  task automatic do_op(input int l, input logic [127:0] w, input logic [127:0] exp, input string tag);
    int n;
    wait_ready(l);
    iv[l] = 1'b1; din[l] = w; ir[l] = 1'b1;
    tick();
    iv[l] = 1'b0;
    chk({tag, "_busy"}, 128'(obusy[l]), 1);
    wait_valid(l, n);
    chk({tag, "_lat"}, 128'(n), 128'(4 >> l));
    chk({tag, "_data"}, dout[l], exp);
    tick();
    chk({tag, "_vld_drop"}, 128'(ov[l]), 0);
    chk({tag, "_rdy_back"}, 128'(ordy[l]), 1);
  endtask

  task automatic round_trip(input int l);
    int idx_in = 0, idx_out = 0, cyc = 0;
    logic acc;
    iv[l] = 1'b1; ir[l] = 1'b1; din[l] = fwd_mix(orig[0]);
    while (idx_out < NRT && cyc < 10 * NRT) begin
      acc = ordy[l] & iv[l];
      if (ov[l] & ir[l]) begin
        chk($sformatf("rt%0d_%0d", l, idx_out), dout[l], orig[idx_out]);
        idx_out++;
      end
      tick(); cyc++;
      if (acc) begin
        idx_in++;
        if (idx_in < NRT) din[l] = fwd_mix(orig[idx_in]);
        else iv[l] = 1'b0;
      end
    end
    iv[l] = 1'b0;
    if (idx_out < NRT) chk("rt_timeout", 128'(idx_out), 128'(NRT));
  endtask

  localparam logic [127:0] FIPS_IN  = 128'h8e4da1bc_9fdc589d_01010101_d5d5d7d6;
  localparam logic [127:0] FIPS_OUT = 128'hdb135345_f20a225c_01010101_d4d4d4d5;
  localparam logic [127:0] UNIT_IN  = 128'h01000000_00000001_00000000_ffffffff;
  localparam logic [127:0] UNIT_OUT = 128'h0e090d0b_090d0b0e_00000000_ffffffff;

  initial begin
    int n;
    for (int l = 0; l < 3; l++) din[l] = '0;
    orig[0] = '0;
    orig[1] = '1;
    for (int i = 2; i < NRT; i++) orig[i] = {$urandom, $urandom, $urandom, $urandom};

    // Reset state
    tick(); tick();
    for (int l = 0; l < 3; l++) begin
      chk($sformatf("rst_rdy%0d", l), 128'(ordy[l]), 0);
      chk($sformatf("rst_vld%0d", l), 128'(ov[l]), 0);
      chk($sformatf("rst_busy%0d", l), 128'(obusy[l]), 0);
      chk($sformatf("rst_dout%0d", l), dout[l], 0);
    end
    rst = 1'b0;
    #1;
    chk("rdy_after_rst", 128'(ordy), 3'b111);

    // FIPS and per-column unit vectors, all widths
    for (int l = 0; l < 3; l++) begin
      do_op(l, FIPS_IN, FIPS_OUT, $sformatf("fips%0d", l));
      do_op(l, UNIT_IN, UNIT_OUT, $sformatf("unit%0d", l));
      do_op(l, '1, '1, $sformatf("ones%0d", l));
    end

    // Backpressure in DONE
    wait_ready(0);
    iv[0] = 1'b1; din[0] = FIPS_IN; ir[0] = 1'b0;
    tick();
    iv[0] = 1'b0;
    wait_valid(0, n);
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("bp_vld%0d", i), 128'(ov[0]), 1);
      chk($sformatf("bp_data%0d", i), dout[0], FIPS_OUT);
      tick();
    end
    ir[0] = 1'b1;
    tick();
    chk("bp_vld_drop", 128'(ov[0]), 0);
    chk("bp_rdy", 128'(ordy[0]), 1);

    // i_valid while busy is ignored
    iv[0] = 1'b1; din[0] = UNIT_IN; ir[0] = 1'b1;
    tick();
    din[0] = FIPS_IN;
    tick(); tick();
    iv[0] = 1'b0;
    wait_valid(0, n);
    chk("busy_ign_data", dout[0], UNIT_OUT);
    tick();
    tick(); tick();
    chk("busy_no_recapture", 128'(obusy[0]), 0);

    // Reset mid-CALC
    iv[0] = 1'b1; din[0] = FIPS_IN;
    tick();
    iv[0] = 1'b0;
    tick(); tick();
    rst = 1'b1;
    tick();
    chk("rmid_vld", 128'(ov[0]), 0);
    chk("rmid_rdy", 128'(ordy[0]), 0);
    chk("rmid_dout", dout[0], 0);
    tick();
    rst = 1'b0;
    #1;
    chk("rmid_rdy_after", 128'(ordy[0]), 1);
    n = 0;
    for (int i = 0; i < 8; i++) begin
      if (ov[0]) n++;
      tick();
    end
    chk("rmid_no_valid", 128'(n), 0);
    do_op(0, FIPS_IN, FIPS_OUT, "rmid_next");

    // Back-to-back round trip through forward model and DUT
    for (int l = 0; l < 3; l++) round_trip(l);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
